// File: rtl/amiq_fifo_status_pkg.sv
// rtl/amiq_fifo_status_pkg.sv - shared types and helpers for the FIFO status generator
//
// Contents:
//   amiq_fifo_status_t : packed per-channel flag bundle
//   STATUS_RESET       : flag values held while rst is asserted
//   lvl_width()        : bits needed to hold a level in the range 0..depth
package amiq_fifo_status_pkg;

  typedef struct packed {
    logic full;
    logic alm_full;
    logic empty;
    logic alm_empty;
    logic overflow;
    logic underflow;
  } amiq_fifo_status_t;

  localparam amiq_fifo_status_t STATUS_RESET = '{
    full:      1'b0,
    alm_full:  1'b0,
    empty:     1'b1,
    alm_empty: 1'b1,
    overflow:  1'b0,
    underflow: 1'b0
  };

  // The level must reach DEPTH itself, hence depth+1 values.
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/amiq_fifo_status_ch.sv
// rtl/amiq_fifo_status_ch.sv - single-channel level counter, flags, sticky errors and watermark
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   push, pop                : write / read strobes for this channel
//   alm_full_thresh          : alm_full when level >= DEPTH - min(thresh, DEPTH)
//   alm_empty_thresh         : alm_empty when level <= thresh
//   err_clr                  : clears sticky overflow/underflow (a new error wins)
//   wm_clr                   : reloads the watermark with the next level
//   level, watermark         : registered fill level and peak level
//   status                   : registered flag bundle
module amiq_fifo_status_ch
  import amiq_fifo_status_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = lvl_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [LVL_W-1:0]  alm_full_thresh,
  input  logic [LVL_W-1:0]  alm_empty_thresh,
  input  logic              err_clr,
  input  logic              wm_clr,
  output logic [LVL_W-1:0]  level,
  output logic [LVL_W-1:0]  watermark,
  output amiq_fifo_status_t status
);

  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  logic             pop_ok;
  logic             push_ok;
  logic [LVL_W-1:0] level_next;
  logic [LVL_W-1:0] af_clamped;
  logic [LVL_W-1:0] af_limit;

  always_comb begin
    // A pop on a full FIFO is always accepted, which is what frees the slot
    // for a simultaneous push; an empty FIFO rejects pop regardless of push.
    pop_ok  = pop && (level != '0);
    push_ok = push && ((level != DEPTH_L) || pop);

    level_next = level;
    if (push_ok && !pop_ok) begin
      level_next = level + LVL_W'(1);
    end else if (pop_ok && !push_ok) begin
      level_next = level - LVL_W'(1);
    end

    // Clamp before subtracting so the limit never wraps below zero.
    af_clamped = (alm_full_thresh > DEPTH_L) ? DEPTH_L : alm_full_thresh;
    af_limit   = DEPTH_L - af_clamped;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level     <= '0;
      watermark <= '0;
      status    <= STATUS_RESET;
    end else begin
      level            <= level_next;
      status.full      <= (level_next == DEPTH_L);
      status.empty     <= (level_next == '0);
      status.alm_full  <= (level_next >= af_limit);
      status.alm_empty <= (level_next <= alm_empty_thresh);
      status.overflow  <= (push && !push_ok) || (status.overflow && !err_clr);
      status.underflow <= (pop && !pop_ok) || (status.underflow && !err_clr);
      if (wm_clr || (level_next > watermark)) begin
        watermark <= level_next;
      end
    end
  end

endmodule

// File: rtl/amiq_fifo_status_gen.sv
// rtl/amiq_fifo_status_gen.sv - multi-channel FIFO status generator top
//
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   push, pop, err_clr, wm_clr        : per-channel strobes, bit i = channel i
//   alm_full_thresh, alm_empty_thresh : thresholds shared by all channels
//   level, watermark                  : channel i at [i*LVL_W +: LVL_W]
//   full, alm_full, empty, alm_empty  : per-channel status flags
//   overflow, underflow               : per-channel sticky errors
module amiq_fifo_status_gen
  import amiq_fifo_status_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NUM_CH = 4,
  parameter int LVL_W  = lvl_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       push,
  input  logic [NUM_CH-1:0]       pop,
  input  logic [LVL_W-1:0]        alm_full_thresh,
  input  logic [LVL_W-1:0]        alm_empty_thresh,
  input  logic [NUM_CH-1:0]       err_clr,
  input  logic [NUM_CH-1:0]       wm_clr,
  output logic [NUM_CH*LVL_W-1:0] level,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       alm_full,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       alm_empty,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH-1:0]       underflow,
  output logic [NUM_CH*LVL_W-1:0] watermark
);

  amiq_fifo_status_t st [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    amiq_fifo_status_ch #(
      .DEPTH (DEPTH),
      .LVL_W (LVL_W)
    ) u_ch (
      .clk              (clk),
      .rst              (rst),
      .push             (push[i]),
      .pop              (pop[i]),
      .alm_full_thresh  (alm_full_thresh),
      .alm_empty_thresh (alm_empty_thresh),
      .err_clr          (err_clr[i]),
      .wm_clr           (wm_clr[i]),
      .level            (level[i*LVL_W +: LVL_W]),
      .watermark        (watermark[i*LVL_W +: LVL_W]),
      .status           (st[i])
    );

    assign full[i]      = st[i].full;
    assign alm_full[i]  = st[i].alm_full;
    assign empty[i]     = st[i].empty;
    assign alm_empty[i] = st[i].alm_empty;
    assign overflow[i]  = st[i].overflow;
    assign underflow[i] = st[i].underflow;
  end

endmodule

// File: tb/tb_amiq_fifo_status_gen.sv
// tb/tb_amiq_fifo_status_gen.sv - self-checking bench for amiq_fifo_status_gen
module tb_amiq_fifo_status_gen;

  localparam int DEPTH  = 8;
  localparam int NUM_CH = 2;
  localparam int LVL_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [NUM_CH-1:0]       push, pop, err_clr, wm_clr;
  logic [LVL_W-1:0]        alm_full_thresh, alm_empty_thresh;
  logic [NUM_CH*LVL_W-1:0] level, watermark;
  logic [NUM_CH-1:0]       full, alm_full, empty, alm_empty, overflow, underflow;

  amiq_fifo_status_gen #(.DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .clk              (clk),
    .rst              (rst),
    .push             (push),
    .pop              (pop),
    .alm_full_thresh  (alm_full_thresh),
    .alm_empty_thresh (alm_empty_thresh),
    .err_clr          (err_clr),
    .wm_clr           (wm_clr),
    .level            (level),
    .full             (full),
    .alm_full         (alm_full),
    .empty            (empty),
    .alm_empty        (alm_empty),
    .overflow         (overflow),
    .underflow        (underflow),
    .watermark        (watermark)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: plain integers per channel.
  int m_lvl [NUM_CH];
  int m_wm  [NUM_CH];
  bit m_full[NUM_CH], m_af[NUM_CH], m_empty[NUM_CH], m_ae[NUM_CH];
  bit m_ovf [NUM_CH], m_udf[NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int af_t;
    bit p, q, pop_acc, push_acc;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        m_lvl[i] = 0; m_wm[i] = 0;
        m_full[i] = 0; m_af[i] = 0; m_empty[i] = 1; m_ae[i] = 1;
        m_ovf[i] = 0; m_udf[i] = 0;
      end else begin
        p = push[i];
        q = pop[i];
        pop_acc  = q && (m_lvl[i] > 0);
        push_acc = p && ((m_lvl[i] < DEPTH) || (m_lvl[i] == DEPTH && q));
        m_ovf[i] = (p && !push_acc) || (m_ovf[i] && !err_clr[i]);
        m_udf[i] = (q && !pop_acc) || (m_udf[i] && !err_clr[i]);
        m_lvl[i] = m_lvl[i] + int'(push_acc) - int'(pop_acc);
        af_t = (int'(alm_full_thresh) > DEPTH) ? DEPTH : int'(alm_full_thresh);
        m_full[i]  = (m_lvl[i] == DEPTH);
        m_empty[i] = (m_lvl[i] == 0);
        m_af[i]    = (m_lvl[i] >= DEPTH - af_t);
        m_ae[i]    = (m_lvl[i] <= int'(alm_empty_thresh));
        if (wm_clr[i] || m_lvl[i] > m_wm[i]) m_wm[i] = m_lvl[i];
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("ch%0d level", i), 32'(level[i*LVL_W +: LVL_W]), 32'(m_lvl[i]));
      check($sformatf("ch%0d watermark", i), 32'(watermark[i*LVL_W +: LVL_W]), 32'(m_wm[i]));
      check($sformatf("ch%0d flags{f,af,e,ae,ov,un}", i),
            32'({full[i], alm_full[i], empty[i], alm_empty[i], overflow[i], underflow[i]}),
            32'({m_full[i], m_af[i], m_empty[i], m_ae[i], m_ovf[i], m_udf[i]}));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    push = '0; pop = '0; err_clr = '0; wm_clr = '0;
  endtask

  initial begin
    rst = 1'b1;
    alm_full_thresh  = 4'd2;
    alm_empty_thresh = 4'd1;
    idle();

    // Reset
    cyc(); cyc();
    check("reset empty", 32'(empty), 32'(2'b11));
    check("reset alm_empty", 32'(alm_empty), 32'(2'b11));
    check("reset full/alm_full/errors", 32'({full, alm_full, overflow, underflow}), 32'(0));
    rst = 1'b0;

    // Fill ch0
    push = 2'b01;
    repeat (6) cyc();
    check("fill6 level", 32'(level[3:0]), 32'(6));
    check("fill6 alm_full/full/alm_empty", 32'({alm_full[0], full[0], alm_empty[0]}), 32'(3'b100));
    repeat (2) cyc();
    check("fill8 full", 32'(full[0]), 32'(1));
    check("fill8 ch1 untouched", 32'({level[7:4], empty[1]}), 32'({4'd0, 1'b1}));

    // Full boundary
    cyc();
    check("overflow on full", 32'({level[3:0], overflow[0]}), 32'({4'd8, 1'b1}));
    push = 2'b01; pop = 2'b01;
    cyc();
    check("push+pop on full", 32'({level[3:0], overflow[0]}), 32'({4'd8, 1'b1}));
    idle(); err_clr = 2'b01;
    cyc();
    check("err_clr overflow", 32'(overflow[0]), 32'(0));

    // Empty boundary
    idle(); push = 2'b10; pop = 2'b10;
    cyc();
    check("push+pop on empty", 32'({level[7:4], underflow[1], empty[1], alm_empty[1]}),
          32'({4'd1, 1'b1, 1'b0, 1'b1}));
    idle(); pop = 2'b10;
    cyc();
    check("pop to empty", 32'({level[7:4], empty[1]}), 32'({4'd0, 1'b1}));

    // Watermark
    idle(); push = 2'b10;
    repeat (5) cyc();
    idle(); pop = 2'b10;
    repeat (3) cyc();
    check("watermark peak", 32'({watermark[7:4], level[7:4]}), 32'({4'd5, 4'd2}));
    idle(); wm_clr = 2'b10;
    cyc();
    check("wm_clr", 32'(watermark[7:4]), 32'(2));

    // Thresholds: bring ch0 to level 3
    idle(); pop = 2'b01;
    repeat (5) cyc();
    idle();
    alm_empty_thresh = 4'd3;
    cyc();
    check("alm_empty thresh change", 32'({level[3:0], alm_empty[0]}), 32'({4'd3, 1'b1}));
    alm_full_thresh = 4'd15;
    cyc();
    check("alm_full clamped", 32'(alm_full), 32'(2'b11));

    // Reset mid-traffic
    push = 2'b11; rst = 1'b1;
    cyc();
    check("mid reset level", 32'(level), 32'(0));
    rst = 1'b0;

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      push    = NUM_CH'($urandom);
      pop     = NUM_CH'($urandom);
      err_clr = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
      wm_clr  = ($urandom_range(0, 9) == 0) ? NUM_CH'($urandom) : '0;
      if ($urandom_range(0, 19) == 0) alm_full_thresh  = LVL_W'($urandom);
      if ($urandom_range(0, 19) == 0) alm_empty_thresh = LVL_W'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      // Bias phases toward filling or draining so both boundaries get hit.
      if ((n / 50) % 2 == 0) push = push | NUM_CH'($urandom);
      else                   pop  = pop  | NUM_CH'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
